// File: rtl/i2c_master_burst.sv
// I2C master running one addressed read or write burst of 0..2^LEN_W-1 bytes.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL; otherwise scl_in is ignored.
module i2c_master_burst #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       slave_address,
    input  logic             rw,
    input  logic [LEN_W-1:0] byte_count,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    input  logic             sda_in,
    input  logic             scl_in,
    output logic             sda_out,
    output logic             scl_out
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP
    } state_t;

    localparam logic [7:0]       DIV_MAX = 8'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t           state_q;
    logic [7:0]       div_q, div_d;
    logic [1:0]       qtr_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic [LEN_W-1:0] rem_q;
    logic             rw_q, samp_q;
    logic             sda_q, scl_q, tx_ready_q, rx_valid_q, busy_q, done_q, nack_q;
    logic [7:0]       rx_data_q;
    logic             stretch, freeze, tick, data_bit;

`ifdef I2C_CLK_STRETCH_EN
    // After releasing SCL, hold the quarter timer until the line is really high.
    assign stretch = (qtr_q == 2'd2) && (state_q != IDLE) && (state_q != START) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stretch       = 1'b0;
`endif

    // A write byte waiting for tx_valid stalls the bus with SCL low.
    assign freeze   = stretch || (tx_ready_q && !tx_valid);
    assign tick     = (state_q != IDLE) && !freeze && (div_q == DIV_MAX);
    assign data_bit = (state_q == ADDR) || (state_q == WRITE) || (state_q == READ);

    always_comb begin
        div_d = div_q;
        if (state_q == IDLE)  div_d = 8'd0;
        else if (freeze)      div_d = div_q;
        else if (tick)        div_d = 8'd0;
        else                  div_d = div_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            sh_q       <= 8'd0;
            rem_q      <= '0;
            rw_q       <= 1'b0;
            samp_q     <= 1'b0;
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            if (state_q == WRITE && tx_ready_q && tx_valid) begin
                tx_ready_q <= 1'b0;
                sh_q       <= tx_data;
                sda_q      <= tx_data[7];
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= START;
                        sh_q    <= {slave_address, rw};
                        rw_q    <= rw;
                        rem_q   <= byte_count;
                        nack_q  <= 1'b0;
                        qtr_q   <= 2'd0;
                        bit_q   <= 3'd0;
                        sda_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (qtr_q == 2'd1) begin
                            state_q <= ADDR;
                            qtr_q   <= 2'd0;
                            scl_q   <= 1'b0;
                            sda_q   <= sh_q[7];
                        end else begin
                            qtr_q <= qtr_q + 2'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (qtr_q)
                            2'd1: scl_q <= 1'b1;
                            2'd2: sda_q <= 1'b1;
                            2'd3: begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (qtr_q)
                            2'd1: scl_q <= 1'b1;
                            2'd2: begin
                                samp_q <= sda_in;
                                if (state_q == READ) begin
                                    sh_q <= {sh_q[6:0], sda_in};
                                    if (bit_q == 3'd7) begin
                                        rx_data_q  <= {sh_q[6:0], sda_in};
                                        rx_valid_q <= 1'b1;
                                    end
                                end
                            end
                            2'd3: begin
                                scl_q <= 1'b0;
                                bit_q <= data_bit ? bit_q + 3'd1 : 3'd0;
                                case (state_q)
                                    ADDR, WRITE: begin
                                        if (bit_q == 3'd7) begin
                                            state_q <= (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
                                            sda_q   <= 1'b1;
                                        end else begin
                                            sh_q  <= {sh_q[6:0], 1'b0};
                                            sda_q <= sh_q[6];
                                        end
                                    end
                                    ADDR_ACK: begin
                                        if (samp_q || rem_q == '0) begin
                                            state_q <= STOP;
                                            sda_q   <= 1'b0;
                                            nack_q  <= samp_q;
                                        end else if (rw_q) begin
                                            state_q <= READ;
                                            sda_q   <= 1'b1;
                                        end else begin
                                            state_q    <= WRITE;
                                            tx_ready_q <= 1'b1;
                                        end
                                    end
                                    WRITE_ACK: begin
                                        if (samp_q) begin
                                            state_q <= STOP;
                                            sda_q   <= 1'b0;
                                            nack_q  <= 1'b1;
                                        end else begin
                                            rem_q <= rem_q - ONE;
                                            if (rem_q == ONE) begin
                                                state_q <= STOP;
                                                sda_q   <= 1'b0;
                                            end else begin
                                                state_q    <= WRITE;
                                                tx_ready_q <= 1'b1;
                                            end
                                        end
                                    end
                                    READ: begin
                                        // Master NACKs the final byte so the slave lets go of SDA.
                                        if (bit_q == 3'd7) begin
                                            state_q <= READ_ACK;
                                            sda_q   <= (rem_q == ONE);
                                        end
                                    end
                                    READ_ACK: begin
                                        rem_q <= rem_q - ONE;
                                        if (rem_q == ONE) begin
                                            state_q <= STOP;
                                            sda_q   <= 1'b0;
                                        end else begin
                                            state_q <= READ;
                                            sda_q   <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_q;
    assign sda_out  = sda_q;
    assign scl_out  = scl_q;

endmodule
